rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource between requesters and produces both a one-hot grant and its 2-bit encoded index. It is the sequencing layer in front of the 4-to-2 encoder datapath. It turns raw request lines into a fair, registered, held grant. The `en` input gates new arbitration, and an optional hold limit forces rotation when a requester holds the grant too long.

## Interface
- `HOLD_MAX`, 8 — maximum consecutive grant cycles for one requester while others wait; used only with the timeout feature, legal range 2..255.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `en`  in  1  — arbitration enable; low drops any grant and blocks new grants.
- `req`  in  4  — request lines; bit i = requester i.
- `gnt`  out  4  — one-hot grant, registered; at most one bit set.
- `gnt_idx`  out  2  — encoded index of the set `gnt` bit, registered; 0 when `gnt_valid` is low.
- `gnt_valid`  out  1  — high when any `gnt` bit is set.

## Operation
- Reset values:
  - `gnt`=4'b0000, `gnt_idx`=2'b00, `gnt_valid`=0.
  - State is IDLE.
  - Internal last-grant pointer `last`=3, so requester 0 has top priority first.
  - Hold counter is 0.
- States: IDLE (no grant) and GRANT (one requester owns the resource).
- Priority search: scan `last+1`, `last+2`, `last+3`, `last` (all mod 4) and take the first requester with `req` set.
- IDLE:
  - `en`=1 and `req`≠0: grant the search winner, set `last`=winner, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT, holder's `req` still high: keep the grant. The counter increments and saturates at `HOLD_MAX`.
- GRANT, holder's `req` low (release):
  - Other requests pending: grant the next search winner directly, with no idle cycle.
  - No other requests: go to IDLE.
  - In both cases the counter clears.
- `en` low in any state: next edge clears `gnt`/`gnt_idx`/`gnt_valid`, goes to IDLE and clears the counter. `last` is retained.
- A new holder's counter starts at 0.
- `req` bits for non-holders never disturb the current grant, except through the timeout rule.

## Timing
- Registered outputs. `req`/`en` sampled at edge N produce a grant visible after edge N, i.e. one-cycle latency.
- Release handover: holder drops `req` in cycle N; the new grant is visible from edge N+1. `gnt` never has two bits set and never shows a gap when another requester is waiting.
- Simultaneous requests: the winner is strictly the rotation order from `last+1`.
- Wrap-around: `last`=3 searches 0,1,2,3.
- Asynchronous `rst` mid-grant clears outputs immediately, without waiting for a clock edge.
- `req` released and reasserted by the same holder in adjacent cycles: the holder re-competes from the rotation order and does not keep priority.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - When the counter reaches `HOLD_MAX`-1 while the holder still requests and any other `req` bit is set, the next edge grants the next search winner and the counter clears.
  - If no other requester is waiting, the holder keeps the grant and the counter saturates.
- Undefined:
  - No counter logic.
  - Grant held until release or `en` low.
  - `HOLD_MAX` is ignored.

## Structure
- Package `arb_pkg`:
  - `N_REQ`=4 and `IDX_W`=2 localparams.
  - State enum {IDLE, GRANT}.
  - Function/typedef for the 2-bit index.
- Sub-module `rr_pick`: combinational rotate-priority encoder.
  - Inputs `req[3:0]` and `last[1:0]`.
  - Outputs `win_idx[1:0]`, `win_oh[3:0]`, `any`.
  - It is the encoder datapath plus rotation.
- The top holds state, pointer, counter and output registers.

## Test plan
- Reset, then `en`=1, `req`=4'b1111 → after one edge `gnt`=0001, `gnt_idx`=0, `gnt_valid`=1.
- From above, requesters drop in turn (bit 0 low, then bit 1 low, ...) → `gnt` sequence 0010, 0100, 1000 on consecutive edges with no gap. All `req` low → `gnt_valid`=0 next edge.
- `last`=2, `req`=4'b0101 → `gnt`=0001 (wrap-around picks 0 before 2).
- Holding `gnt`=0100, drive `en`=0 for one cycle → outputs zero next edge. `en`=1 with `req`=0100 → `gnt`=1000 if bit 3 requests, else 0100.
- With `RR_ARB_TIMEOUT_EN`, `HOLD_MAX`=4, `req`=4'b0011 held high → `gnt`=0001 for 4 cycles, then 0010 for 4, alternating. Without the macro → 0001 indefinitely.
- Assert `rst` between edges while `gnt`=0010 → outputs 0 immediately. Release `rst` with `req`=4'b1010 → next edge `gnt`=0010 (pointer reset to 3, search 0,1,...).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Combinational helpers only; no latency of their own.
// No flow control here; consumers apply their own handshakes.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot expansion of a requester index.
  function automatic logic [N_REQ-1:0] idx2oh(input idx_t idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Pure wiring; no latency.
// Arbiter side (slave) consumes en/req and drives the grant signals.
interface rr_arbiter4_if
  import arb_pkg::*;
  ;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  idx_t             gnt_idx;
  logic             gnt_valid;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set req bit scanning last+1, last+2, last+3, last.
// Purely combinational, zero latency.
// No backpressure; any=0 when no request line is set.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             last,
  output idx_t             win_idx,
  output logic [N_REQ-1:0] win_oh,
  output logic             any
);

  idx_t w_cand;

  // Scan in rotation order starting just after the previous winner.
  always_comb begin
    win_idx = '0;
    any     = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = last + idx_t'(k);
      if (!any && req[w_cand]) begin
        any     = 1'b1;
        win_idx = w_cand;
      end
    end
    win_oh = any ? idx2oh(win_idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and index.
// One-cycle latency from req/en to grant; handover on release has no idle cycle.
// en low drops the grant; with RR_ARB_TIMEOUT_EN a holder is rotated out after HOLD_MAX cycles if others wait.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter4_if.slave bus
);

  // Reject hold limits the counter cannot represent.
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arbiter4: HOLD_MAX out of range 2..255");
  end

  state_t           r_state, w_state_nxt;
  idx_t             r_last, w_last_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  idx_t             r_idx, w_idx_nxt;
  logic             r_vld, w_vld_nxt;

  idx_t             w_win_idx;
  logic [N_REQ-1:0] w_win_oh;
  logic             w_any;
  logic             w_hold_req;
  logic             w_timeout;
  logic             w_take;
  logic             w_drop;

  rr_pick u_pick (
    .req     (bus.req),
    .last    (r_last),
    .win_idx (w_win_idx),
    .win_oh  (w_win_oh),
    .any     (w_any)
  );

  // The holder is always the last winner, so its request line is req[last].
  assign w_hold_req = bus.req[r_last];

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_MAX  = 8'(HOLD_MAX);
  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] r_cnt;
  logic       w_others;
  logic       w_keep;

  assign w_others  = |(bus.req & ~idx2oh(r_last));
  assign w_timeout = (r_cnt == CNT_LAST) && w_others;
  assign w_keep    = bus.en && (r_state == GRANT) && w_hold_req && !w_timeout;

  // Consecutive-hold counter: counts while the holder keeps the grant, saturates, clears otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_keep) begin
      r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and next-output decision: take a new winner, drop to idle, or hold.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = r_vld;
    w_take      = 1'b0;
    w_drop      = 1'b0;

    if (!bus.en) begin
      w_drop = 1'b1;
    end else if (r_state == IDLE) begin
      w_take = w_any;
    end else if (w_hold_req) begin
      // Holder stays unless it has been rotated out by the hold limit.
      w_take = w_timeout;
    end else if (w_any) begin
      w_take = 1'b1;
    end else begin
      w_drop = 1'b1;
    end

    if (w_take) begin
      w_state_nxt = GRANT;
      w_last_nxt  = w_win_idx;
      w_gnt_nxt   = w_win_oh;
      w_idx_nxt   = w_win_idx;
      w_vld_nxt   = 1'b1;
    end else if (w_drop) begin
      w_state_nxt = IDLE;
      w_gnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_vld_nxt   = 1'b0;
    end
  end

  // State, pointer and output registers; pointer resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= idx_t'(N_REQ - 1);
      r_gnt   <= '0;
      r_idx   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_idx;
  assign bus.gnt_valid = r_vld;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with a behavioural round-robin model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Model tracks holder, last winner and hold count as plain integers.
module tb_rr_arbiter4;

  localparam int HM = 4;

  logic clk;
  logic rst;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.HOLD_MAX(HM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_last = 3;
  int m_hold = -1;
  int m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 3;
    m_hold = -1;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] r);
    int w;
    bit others;
    w = search(r, m_last);
    if (!e) begin
      m_hold = -1;
      m_cnt  = 0;
    end else if (m_hold < 0) begin
      if (w >= 0) begin
        m_hold = w;
        m_last = w;
        m_cnt  = 0;
      end
    end else if (r[m_hold]) begin
      others = ((r & ~(4'b0001 << m_hold)) != 4'b0000);
`ifdef RR_ARB_TIMEOUT_EN
      if (m_cnt == HM - 1 && others) begin
        m_hold = w;
        m_last = w;
        m_cnt  = 0;
      end else begin
        m_cnt = (m_cnt < HM) ? m_cnt + 1 : HM;
      end
`else
      if (others) m_cnt = 0;
`endif
    end else begin
      m_hold = w;
      if (w >= 0) m_last = w;
      m_cnt = 0;
    end
  endtask

  task automatic model_cmp();
    logic [3:0] eg;
    logic [1:0] ei;
    logic       ev;
    eg = (m_hold < 0) ? 4'b0000 : (4'b0001 << m_hold);
    ei = (m_hold < 0) ? 2'd0 : 2'(m_hold);
    ev = (m_hold >= 0);
    chk("model_gnt", 32'(bus.gnt), 32'(eg));
    chk("model_idx", 32'(bus.gnt_idx), 32'(ei));
    chk("model_vld", 32'(bus.gnt_valid), 32'(ev));
  endtask

  // One clock: apply inputs, advance model on the edge, compare on the falling edge.
  task automatic cyc(input logic e, input logic [3:0] r);
    bus.en  = e;
    bus.req = r;
    @(posedge clk);
    model_step(e, r);
    @(negedge clk);
    model_cmp();
  endtask

  typedef struct packed {
    logic       e;
    logic [3:0] r;
  } vec_t;

  vec_t mix [12] = '{
    '{1'b1, 4'b1010}, '{1'b1, 4'b1010}, '{1'b1, 4'b1000}, '{1'b1, 4'b0110},
    '{1'b0, 4'b0110}, '{1'b1, 4'b0110}, '{1'b1, 4'b0010}, '{1'b1, 4'b1101},
    '{1'b1, 4'b1100}, '{1'b1, 4'b0001}, '{1'b1, 4'b1111}, '{1'b1, 4'b0000}
  };

  initial begin
    bus.en  = 1'b0;
    bus.req = 4'b0000;
    rst     = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_vld", 32'(bus.gnt_valid), 32'h0);
    model_cmp();
    rst = 1'b0;

    // All request: requester 0 first after reset
    cyc(1'b1, 4'b1111);
    chk("first_gnt", 32'(bus.gnt), 32'h1);
    chk("first_idx", 32'(bus.gnt_idx), 32'h0);
    chk("first_vld", 32'(bus.gnt_valid), 32'h1);

    // Requesters drop in turn: seamless handover
    cyc(1'b1, 4'b1110);
    chk("hand_1", 32'(bus.gnt), 32'h2);
    cyc(1'b1, 4'b1100);
    chk("hand_2", 32'(bus.gnt), 32'h4);
    cyc(1'b1, 4'b1000);
    chk("hand_3", 32'(bus.gnt), 32'h8);
    chk("hand_3_idx", 32'(bus.gnt_idx), 32'h3);
    cyc(1'b1, 4'b0000);
    chk("all_low_vld", 32'(bus.gnt_valid), 32'h0);

    // Set last=2, then 0101 wraps to requester 0
    cyc(1'b1, 4'b0100);
    cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0101);
    chk("wrap_gnt", 32'(bus.gnt), 32'h1);

    // Hold 0100, then en low
    cyc(1'b1, 4'b0100);
    chk("hold_2", 32'(bus.gnt), 32'h4);
    cyc(1'b1, 4'b0100);
    cyc(1'b0, 4'b0100);
    chk("en_low_gnt", 32'(bus.gnt), 32'h0);
    chk("en_low_vld", 32'(bus.gnt_valid), 32'h0);
    cyc(1'b1, 4'b1100);
    chk("en_back_b3", 32'(bus.gnt), 32'h8);
    cyc(1'b0, 4'b0000);
    cyc(1'b1, 4'b0100);
    chk("en_back_b2", 32'(bus.gnt), 32'h4);

    // Two requesters held high: last=2 so 0 wins first
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] want;
`ifdef RR_ARB_TIMEOUT_EN
      want = (((i / HM) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
      want = 4'b0001;
`endif
      cyc(1'b1, 4'b0011);
      chk("hold_pair", 32'(bus.gnt), 32'(want));
    end

    // Lone holder keeps the grant well past the limit
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 2 * HM + 2; i++) begin
      cyc(1'b1, 4'b0100);
      chk("lone_hold", 32'(bus.gnt), 32'h4);
    end

    // Release then reassert: holder 0 re-competes behind 1
    cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0001);
    chk("reass_a", 32'(bus.gnt), 32'h1);
    cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0011);
    chk("reass_b", 32'(bus.gnt), 32'h2);

    // Mixed table
    foreach (mix[i]) cyc(mix[i].e, mix[i].r);

    // Asynchronous reset mid-grant
    cyc(1'b1, 4'b0010);
    cyc(1'b1, 4'b0010);
    chk("pre_rst", 32'(bus.gnt), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    chk("async_vld", 32'(bus.gnt_valid), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 4'b1010);
    chk("post_rst", 32'(bus.gnt), 32'h2);
    chk("post_rst_idx", 32'(bus.gnt_idx), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
